// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan path: digit geometry and
// the per-digit storage record used by the scanner and the segment decoder.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 3;

    typedef struct packed {
        logic               blank;
        logic               dp;
        logic [DIGIT_W-1:0] value;
    } digit_t;

    // Power-up / reset content of every digit: dark, no point, value 0.
    localparam digit_t DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, value: 4'h0};

    // A digit counts as zero for leading-zero purposes when it reads 0 or is
    // blanked (a dark digit cannot anchor a visible number to its right).
    function automatic logic digit_is_zero(input digit_t d);
        return d.blank | (d.value == 4'h0);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_refresh_prescaler.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and flags the terminal-count
// cycle with a registered one-cycle tick.
module refresh_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tick_r;

    // Next count value with wrap at the terminal count.
    always_comb begin
        cnt_next_s = '0;
        if (cnt_r == TERM) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Count register plus tick pre-decoded from the next count so the tick
    // is high exactly while the counter sits at the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == TERM);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit scan controller: per-digit storage with a write
// port, leading-zero suppression, and registered num/sel/dp/digit_active
// outputs feeding the combinational segment/anode decoder.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_addr,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic               wr_dp,
    input  logic               wr_blank,
    input  logic               lz_suppress,
    output logic [DIGIT_W-1:0] num,
    output logic [SEL_W-1:0]   sel,
    output logic               dp,
    output logic               digit_active,
    output logic               frame_tick
);

    digit_t                store_r [NUM_DIGITS];
    logic                  tick_s;
    logic [SEL_W-1:0]      scan_idx_r;
    logic [SEL_W-1:0]      scan_next_s;
    logic [NUM_DIGITS-1:0] supp_s;
    logic [NUM_DIGITS-1:0] vis_s;
    digit_t                cur_s;
    logic                  cur_vis_s;

    refresh_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Digit storage: all three fields of the addressed digit replaced together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                store_r[i] <= DIGIT_RESET;
            end
        end else if (wr_en) begin
            store_r[wr_addr] <= '{blank: wr_blank, dp: wr_dp, value: wr_data};
        end
    end

    // Scan index after this edge; the 3-bit add wraps 7 back to 0.
    always_comb begin
        scan_next_s = scan_idx_r;
        if (tick_s) begin
            scan_next_s = scan_idx_r + SEL_W'(1);
        end else begin
            scan_next_s = scan_idx_r;
        end
    end

    // Scan index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx_r <= '0;
        end else begin
            scan_idx_r <= scan_next_s;
        end
    end

    // Leading-zero mask: digit i (i>=1) is hidden when it and every digit to
    // its left read zero; digit 0 always shows so a value of 0 stays visible.
    always_comb begin
        logic all_zero_v;
        supp_s     = '0;
        all_zero_v = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero_v = all_zero_v & digit_is_zero(store_r[i]);
            supp_s[i]  = lz_suppress & all_zero_v;
        end
    end

    // Per-digit visibility and selection of the digit being presented.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            vis_s[i] = ~store_r[i].blank & ~supp_s[i];
        end
        cur_s     = store_r[scan_next_s];
        cur_vis_s = vis_s[scan_next_s];
    end

    // Registered decoder-facing outputs; a hidden digit keeps its value on
    // num but has its point forced dark and its anode gated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num          <= '0;
            sel          <= '0;
            dp           <= 1'b1;
            digit_active <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            num          <= cur_s.value;
            sel          <= scan_next_s;
            dp           <= ~(cur_s.dp & cur_vis_s);
            digit_active <= cur_vis_s;
            frame_tick   <= tick_s & (scan_idx_r == SEL_W'(NUM_DIGITS - 1));
        end
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan controller for the 8-digit seven-segment display. Holds one 4-bit value, decimal-point flag and blank flag per digit, written through a single-cycle write port. A refresh prescaler steps through digits 0..7, presenting the current digit's `num`/`sel` pair to the seven-segment decoder together with decimal-point and digit-active qualifiers. Sits between the system/register logic and the combinational segment/anode decoder.

## Interface
- `REFRESH_DIV`, 100000, clock cycles each digit is held (≥2)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  write strobe, sampled each rising edge
- `wr_addr`  in  3  digit index written (0 = rightmost)
- `wr_data`  in  4  hex value written
- `wr_dp`  in  1  decimal-point flag written (1 = lit)
- `wr_blank`  in  1  blank flag written (1 = digit dark)
- `lz_suppress`  in  1  leading-zero suppression enable, level
- `num`  out  4  value of scanned digit, to decoder
- `sel`  out  3  index of scanned digit, to decoder
- `dp`  out  1  decimal point, active-low (0 = lit)
- `digit_active`  out  1  1 = scanned digit visible; 0 = anode must be gated off
- `frame_tick`  out  1  one-cycle pulse per completed 8-digit frame

## Operation
- Storage: 8 entries {blank, dp, value}. Write on rising edge when `wr_en`=1; all three fields replaced together.
- Prescaler counts 0..REFRESH_DIV-1, wraps to 0. On the terminal-count cycle, `scan_idx` increments; 7 wraps to 0.
- Every cycle outputs register from storage at `scan_idx`: `sel`<=scan_idx, `num`<=value, `dp`<=~(dp & visible), `digit_active`<=visible.
- visible = ~blank & ~suppressed. Suppressed (only when `lz_suppress`=1): digit i≥1 whose value and the values of all digits i+1..7 are 0 (blanked digits count as 0). Digit 0 is never suppressed.
- Hidden digit: `num` still shows stored value; `digit_active`=0, `dp`=1.
- `frame_tick`=1 for exactly the cycle in which `sel` changes from 7 to 0.

## Timing
- Reset (asynchronous, immediate): storage all {blank=1, dp=0, value=0}; prescaler=0; scan_idx=0; `num`=0, `sel`=0, `dp`=1, `digit_active`=0, `frame_tick`=0.
- After reset release: first edge loads outputs from digit 0; `sel` advances after REFRESH_DIV cycles, then every REFRESH_DIV cycles.
- Write latency: write at edge N reaches outputs at edge N+1 if that digit is scanned (including suppression changes).
- Write to scanned digit on the same edge as scan advance: storage updates; outputs take the new scan digit's pre-write storage.
- Reset mid-frame: no partial frame_tick; scanning restarts at digit 0.
- `lz_suppress` change takes effect on the next edge.

## Structure
- `seven_seg_pkg`: NUM_DIGITS=8, DIGIT_W=4, SEL_W=3, `digit_t` packed struct {blank, dp, value}; shared with the segment decoder.
- Sub-module `refresh_prescaler` (parameter REFRESH_DIV; outputs one-cycle `tick` at terminal count, async reset to 0).
- Suppression mask: combinational from storage, 8 bits.

## Test plan
- REFRESH_DIV=4, reset then no writes -> `sel` steps 0..7 every 4 cycles, `digit_active`=0, `dp`=1 throughout; `frame_tick` one cycle at 7->0.
- Write digits 0..7 = 1..8, dp on digit 2 -> `num`=sel+1, `digit_active`=1, `dp`=0 only while `sel`=2.
- Digits {7..0}={0,0,0,0,0,1,0,0}, `lz_suppress`=1 -> digits 7..3 inactive; digits 2,1,0 active showing 1,0,0; `lz_suppress`=0 -> all 8 active.
- Write 0xA to digit 5 while `sel`=5 -> `num`=0xA next cycle; write with `wr_blank`=1 -> `digit_active`=0 next cycle.
- Assert `rst` asynchronously mid-digit 4 -> outputs at reset values before the next edge; storage blanked; scan resumes from digit 0.
